// File: rtl/adder_acc_pipe_if.sv
// Operand/result handshake bundle for adder_acc_pipe.
// The producer and consumer drive the master side; the adder takes the slave side.
interface adder_acc_pipe_if #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned CHANNELS = 2
);
   localparam int unsigned CW  = WIDTH + 3;
   localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic             in_valid;
   logic             in_ready;
   logic [CHW-1:0]   in_ch;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             acc_mode;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [CHW-1:0]   out_ch;
   logic [CW-1:0]    c;
   logic             out_ovf;
   logic             out_err;

   modport master (
      output in_valid, in_ch, a, b, acc_mode, acc_clr, out_ready,
      input  in_ready, out_valid, out_ch, c, out_ovf, out_err
   );

   modport slave (
      input  in_valid, in_ch, a, b, acc_mode, acc_clr, out_ready,
      output in_ready, out_valid, out_ch, c, out_ovf, out_err
   );
endinterface

// File: rtl/adder_acc_pipe.sv
// Multi-channel pipelined adder/accumulator with valid/ready on both sides.
// Optional macro ADDER_ACC_SAT_EN: accumulators saturate at all-ones instead of wrapping.
module adder_acc_pipe #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned STAGES   = 2
) (
   input  logic             clk,
   input  logic             reset,
   adder_acc_pipe_if.slave  bus
);
   localparam int unsigned CW    = WIDTH + 3;
   localparam int unsigned CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned ACC_N = 1 << CHW;

   typedef struct packed {
      logic [CHW-1:0] ch;
      logic [CW-1:0]  c;
      logic           ovf;
      logic           err;
   } res_t;

   logic           run_q;
   logic           stall_c;
   logic           accept_c;
   logic           ch_err_c;
   logic [CW-1:0]  s_c;
   logic [CW-1:0]  base_c;
   logic [CW:0]    r_c;
   logic [CW-1:0]  acc_nx_c;
   res_t           res_c;

   logic [CW-1:0]  acc_q [ACC_N];
   logic           pv_q  [STAGES];
   res_t           pd_q  [STAGES];

   // Handshake: only a held, unconsumed output blocks the whole pipe.
   assign stall_c      = pv_q[STAGES-1] && !bus.out_ready;
   assign bus.in_ready = run_q && !stall_c;
   assign accept_c     = bus.in_valid && bus.in_ready;

   // Out-of-range channel detection; impossible when CHANNELS fills the index space.
   generate
      if (CHANNELS == ACC_N) begin : g_ch_full
         assign ch_err_c = 1'b0;
      end else begin : g_ch_part
         assign ch_err_c = (bus.in_ch >= CHW'(CHANNELS));
      end
   endgenerate

   // Result for the transfer being offered this cycle.
   always_comb begin
      s_c    = CW'(bus.a) + CW'(bus.b);
      base_c = bus.acc_clr ? '0 : acc_q[bus.in_ch];
      r_c    = {1'b0, base_c} + {1'b0, s_c};
`ifdef ADDER_ACC_SAT_EN
      acc_nx_c = r_c[CW] ? '1 : r_c[CW-1:0];
`else
      acc_nx_c = r_c[CW-1:0];
`endif
      res_c    = '0;
      res_c.ch = bus.in_ch;
      if (ch_err_c) begin
         res_c.err = 1'b1;
      end else if (bus.acc_mode) begin
         res_c.c   = acc_nx_c;
         res_c.ovf = r_c[CW];
      end else begin
         res_c.c   = s_c;
      end
   end

   // in_ready is held low until the first edge with reset released.
   always_ff @(posedge clk) begin
      if (!reset) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   // Accumulators update at acceptance so back-to-back accumulates chain without bubbles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < ACC_N; i++) acc_q[i] <= '0;
      end else if (accept_c && bus.acc_mode && !ch_err_c) begin
         acc_q[bus.in_ch] <= acc_nx_c;
      end
   end

   // Lock-step pipeline: every stage, bubbles included, advances unless stalled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            pv_q[k] <= 1'b0;
            pd_q[k] <= '0;
         end
      end else if (!stall_c) begin
         pv_q[0] <= accept_c;
         pd_q[0] <= accept_c ? res_c : '0;
         for (int unsigned k = 1; k < STAGES; k++) begin
            pv_q[k] <= pv_q[k-1];
            pd_q[k] <= pd_q[k-1];
         end
      end
   end

   assign bus.out_valid = pv_q[STAGES-1];
   assign bus.out_ch    = pd_q[STAGES-1].ch;
   assign bus.c         = pd_q[STAGES-1].c;
   assign bus.out_ovf   = pd_q[STAGES-1].ovf;
   assign bus.out_err   = pd_q[STAGES-1].err;
endmodule

// File: doc/adder_acc_pipe.md
Name: adder_acc_pipe

Overview:
Parametrised, multi-channel successor to the basic registered adder. Two WIDTH-bit operands are added either as a plain sum or into a per-channel running accumulator. Results pass through a STAGES-deep pipeline with valid/ready handshakes on both sides. It sits between operand producers and result consumers in the datapath and is the drop-in upgrade path for the single-channel adder.

Parameters:
WIDTH, 4, operand width in bits (2..32)
CHANNELS, 2, number of independent accumulators (1..16)
STAGES, 2, pipeline depth = acceptance-to-output latency in cycles (1..4)
CW (localparam), WIDTH+3, result/accumulator width
CHW (localparam), max(1,$clog2(CHANNELS)), channel-index width

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  operand transfer request
in_ready  out  1  block can accept operands this cycle
in_ch  in  CHW  target channel
a  in  WIDTH  operand A, unsigned
b  in  WIDTH  operand B, unsigned
acc_mode  in  1  0 = plain add, 1 = accumulate into acc[in_ch]
acc_clr  in  1  with accepted transfer: clear acc[in_ch] before the add
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_ch  out  CHW  channel of result
c  out  CW  result
out_ovf  out  1  result overflowed CW bits (wrapped or saturated)
out_err  out  1  in_ch >= CHANNELS for this transaction

Behaviour:
- Single clock domain. Reset is synchronous and active-low. While reset==0 at a clk edge: all pipeline valid bits, out_valid, c, out_ch, out_ovf and out_err are 0. All accumulators are 0. in_ready is 0 during reset and 1 in the first cycle after release.
- Accept when in_valid && in_ready. Stall = out_valid && !out_ready. in_ready = !stall.
- The whole pipeline, including bubbles, advances together on any non-stall cycle and holds every stage when stalled. Output signals stay stable while out_valid && !out_ready.
- Stage 1 registers the computed result in the acceptance cycle. Stages 2..STAGES are pure delay. out_valid rises exactly STAGES cycles after acceptance. Throughput is 1 transaction per cycle when out_ready=1.
- Sum: s = a + b, zero-extended to CW bits. It never overflows by itself.
- acc_mode=0: c = s. The accumulator is untouched. acc_clr is ignored. out_ovf = 0.
- acc_mode=1:
  - base = acc_clr ? 0 : acc[in_ch]; r = base + s, computed at CW+1 bits.
  - acc[in_ch] and c both take the CW-bit result, which is wrapped or saturated (see Optional Feature). out_ovf = r[CW].
- Accumulators update in the acceptance cycle. Back-to-back accumulates to the same channel therefore see each other's results with no hazard and no bubble.
- in_ch >= CHANNELS: the transfer is still accepted. No accumulator changes. c = 0, out_err = 1, out_ovf = 0.
- acc_clr with acc_mode=1 and a = b = 0 is the supported way to zero a channel. It produces an output of c = 0.
- Reset asserted mid-operation: in-flight results are discarded with no output. Accumulators are zeroed.
- Accumulators of other channels are never disturbed by a transaction.

Optional Feature:
Macro ADDER_ACC_SAT_EN.
- Defined: on accumulate overflow (r[CW]=1), acc and c saturate to all-ones (2^CW-1). Once saturated, the channel stays at max until cleared or reset. out_ovf=1 on every transaction that saturates or stays saturated with s != 0.
- Undefined: acc and c take r modulo 2^CW (wrap). out_ovf=1 only on the wrapping transaction.

Test Plan:
1. Reset/latency (WIDTH=4, STAGES=2): hold reset=0 for 3 cycles, then release. Send a=9, b=7, acc_mode=0 -> out_valid exactly 2 cycles after acceptance, c=16, out_ovf=0. All outputs are 0 during reset.
2. Accumulate streaming, ch0: a=15, b=15, acc_mode=1, 3 consecutive cycles, out_ready=1 -> c = 30, 60, 90 on consecutive cycles; in_ready stays 1.
3. Channel isolation: ch0 acc=90, then ch1 a=1, b=2, acc_mode=1 -> c=3, out_ch=1. Next ch0 a=0, b=0 -> c=90. Then ch0 with acc_clr=1, a=4, b=1 -> c=5.
4. Overflow: ch0 accumulates a=15, b=15 five times (CW=7, max 127) -> 4th result is 120. 5th result: wrap build gives c=22, out_ovf=1; ADDER_ACC_SAT_EN build gives c=127, out_ovf=1.
5. Back-pressure: out_ready=0 for 4 cycles with in_valid=1 continuously -> in_ready=0 once the output is occupied. c, out_ch and out_valid are held. No transaction is lost or duplicated after out_ready=1; results arrive in order.
6. Error/reset mid-flight: CHANNELS=3, in_ch=3 -> out_err=1, c=0, accumulators unchanged. Then accept 2 transactions and assert reset before they exit -> no out_valid, and all accumulators read 0 afterwards.
